// File: rtl/ii_frame_scheduler_if.sv
// Bundle between the II frame scheduler and its neighbours: capture, detector, RAM.
// Latency: none, this is wiring only.
// Backpressure: detector reads are granted through det_gnt; capture writes cannot stall.
interface ii_frame_scheduler_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_done;
    logic              det_req;
    logic [ADDR_W-1:0] det_addr;
    logic              det_gnt;
    logic              det_rd_valid;
    logic [DATA_W-1:0] det_rd_data;
    logic              frame_ready;
    logic              frame_bank;
    logic              frame_release;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [7:0]        dropped_frames;

    // Scheduler side.
    modport master (
        input  cap_we, cap_addr, cap_data, cap_done,
        input  det_req, det_addr, frame_release, mem_rdata,
        output det_gnt, det_rd_valid, det_rd_data, frame_ready, frame_bank,
        output mem_en, mem_we, mem_addr, mem_wdata, dropped_frames
    );

    // Capture, detector and RAM side.
    modport slave (
        output cap_we, cap_addr, cap_data, cap_done,
        output det_req, det_addr, frame_release, mem_rdata,
        input  det_gnt, det_rd_valid, det_rd_data, frame_ready, frame_bank,
        input  mem_en, mem_we, mem_addr, mem_wdata, dropped_frames
    );
endinterface

// File: rtl/ii_frame_scheduler.sv
// Two-bank II store sequencer: capture writes to bank wb, committed frames handed to detector.
// Latency: RAM command 1 cycle after write/grant; read data valid 2 cycles after grant.
// Backpressure: capture writes always win the port; detector holds det_req until det_gnt.
// Optional: define II_SCHED_STATS_EN to enable the saturating dropped_frames counter.
module ii_frame_scheduler #(
    parameter int FRAME_WORDS = 19200,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32
) (
    input  logic                 ov7670_pclk,
    input  logic                 rst,
    ii_frame_scheduler_if.master bus
);
    localparam logic [ADDR_W-1:0] FRAME_LEN = ADDR_W'(FRAME_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wcnt;
    logic              bad;
    logic              wb;
    logic              frame_ready;
    logic              frame_bank;
    logic              rd_pipe;
    logic              rd_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic addr_ok;
    logic wr_acc;
    logic wr_bad;
    logic det_gnt;
    logic ready_after_rel;
    logic frame_good;

    assign addr_ok = bus.cap_addr < FRAME_LEN;
    assign wr_acc  = (state == CAPTURE) && bus.cap_we && addr_ok;
    assign wr_bad  = (state == CAPTURE) && bus.cap_we && !addr_ok;
    assign det_gnt = bus.det_req && frame_ready && !wr_acc;

    // A release arriving in the commit cycle frees the slot before the new frame is judged.
    assign ready_after_rel = frame_ready && !bus.frame_release;
    assign frame_good      = (wcnt == FRAME_LEN) && !bad && !ready_after_rel;

    // Writer FSM state register.
    always_ff @(posedge ov7670_pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Writer FSM next state; CAPTURE is only entered with cap_done low, so a high level there is the rising edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.cap_done) state_nxt = CAPTURE;
            CAPTURE: if (bus.cap_done)  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-frame word count (saturating so runaway frames never alias to a full count) and bad flag.
    always_ff @(posedge ov7670_pclk) begin
        if (rst || state == COMMIT) begin
            wcnt <= '0;
            bad  <= 1'b0;
        end else begin
            if (wr_acc && wcnt != '1) wcnt <= wcnt + ADDR_W'(1);
            if (wr_bad)               bad  <= 1'b1;
        end
    end

    // Frame hand-off: release clears the slot, a good commit fills it and flips the write bank.
    always_ff @(posedge ov7670_pclk) begin
        if (rst) begin
            frame_ready <= 1'b0;
            frame_bank  <= 1'b0;
            wb          <= 1'b0;
        end else begin
            if (bus.frame_release) frame_ready <= 1'b0;
            if (state == COMMIT && frame_good) begin
                frame_ready <= 1'b1;
                frame_bank  <= wb;
                wb          <= ~wb;
            end
        end
    end

`ifdef II_SCHED_STATS_EN
    logic [7:0] drop_cnt;

    // Count frames rejected at commit, holding at 255.
    always_ff @(posedge ov7670_pclk) begin
        if (rst)
            drop_cnt <= '0;
        else if (state == COMMIT && !frame_good && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

    assign bus.dropped_frames = drop_cnt;
`else
    assign bus.dropped_frames = '0;
`endif

    // Registered RAM command: accepted capture write first, else a granted detector read.
    always_ff @(posedge ov7670_pclk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= wr_acc || det_gnt;
            mem_we <= wr_acc;
            if (wr_acc) begin
                mem_addr  <= {wb, bus.cap_addr};
                mem_wdata <= bus.cap_data;
            end else if (det_gnt) begin
                mem_addr  <= {frame_bank, bus.det_addr};
                mem_wdata <= '0;
            end else begin
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

    // Read-valid pipeline: one stage for the RAM command, one for the RAM's read latency.
    always_ff @(posedge ov7670_pclk) begin
        if (rst) begin
            rd_pipe  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_pipe  <= det_gnt;
            rd_valid <= rd_pipe;
        end
    end

    assign bus.det_gnt      = det_gnt;
    assign bus.det_rd_valid = rd_valid;
    assign bus.det_rd_data  = bus.mem_rdata;
    assign bus.frame_ready  = frame_ready;
    assign bus.frame_bank   = frame_bank;
    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
endmodule

// File: tb/tb_ii_frame_scheduler.sv
// Bench for ii_frame_scheduler: random frames and reads against a frame-level reference model.
// Scaled frame size keeps full-frame scenarios short; addresses and counts follow the same rules.
// RAM is modelled here; write and read scoreboards are drained by a negedge monitor.
module tb_ii_frame_scheduler;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int FW     = 64;
    localparam logic [ADDR_W-1:0] FW_A = ADDR_W'(FW);

    logic clk;
    logic rst;

    ii_frame_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ii_frame_scheduler #(
        .FRAME_WORDS (FW),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .ov7670_pclk (clk),
        .rst         (rst),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with one cycle of read latency.
    logic [DATA_W-1:0] ram [0:65535];
    logic [DATA_W-1:0] ram_q;
    always @(posedge clk) begin
        if (rst) ram_q <= '0;
        else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ram_q;

    int unsigned cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    typedef struct { logic [ADDR_W:0] addr; logic [DATA_W-1:0] data; } wr_t;
    typedef struct { logic [DATA_W-1:0] data; int unsigned due; } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    // Reference model: frame-level bookkeeping of banks and hand-off.
    logic [DATA_W-1:0] img [0:65535];
    logic m_cap   = 1'b0;
    logic m_wb    = 1'b0;
    logic m_ready = 1'b0;
    logic m_bank  = 1'b0;
    logic m_bad   = 1'b0;
    int   m_cnt   = 0;
    int   m_drops = 0;

    function automatic logic [7:0] exp_drops();
`ifdef II_SCHED_STATS_EN
        return (m_drops > 255) ? 8'hFF : 8'(m_drops);
`else
        return 8'h00;
`endif
    endfunction

    // Monitor: every RAM write and every read return must match the next expected item.
    always @(negedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            if (wq.size() == 0) check("unexpected_write", 64'(bus.mem_addr), 64'hFFFF_FFFF);
            else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
                check("wr_data", 64'(bus.mem_wdata), 64'(w.data));
            end
        end
        if (bus.det_rd_valid) begin
            if (rq.size() == 0) check("unexpected_read", 64'(bus.det_rd_data), 64'hFFFF_FFFF);
            else begin
                rd_t r;
                r = rq.pop_front();
                check("rd_data", 64'(bus.det_rd_data), 64'(r.data));
                check("rd_latency", 64'(cyc), 64'(r.due));
            end
        end
    end

    // One clock of stimulus: predict this cycle's effect, check the grant, advance.
    task automatic tick();
        logic acc, gnt_e;
        acc = !rst && m_cap && bus.cap_we && (bus.cap_addr < FW_A);
        if (!rst && m_cap && bus.cap_we && !(bus.cap_addr < FW_A)) m_bad = 1'b1;
        gnt_e = !rst && bus.det_req && m_ready && !acc;
        if (acc) begin
            img[{m_wb, bus.cap_addr}] = bus.cap_data;
            wq.push_back('{addr: {m_wb, bus.cap_addr}, data: bus.cap_data});
            m_cnt++;
        end
        if (gnt_e) rq.push_back('{data: img[{m_bank, bus.det_addr}], due: cyc + 2});
        @(negedge clk);
        check("det_gnt", 64'(bus.det_gnt), 64'(gnt_e));
        @(posedge clk);
        #1;
        if (gnt_e) bus.det_addr = ADDR_W'($urandom_range(FW - 1));
    endtask

    task automatic check_handoff(input string nm);
        check({nm, "_ready"}, 64'(bus.frame_ready), 64'(m_ready));
        check({nm, "_bank"},  64'(bus.frame_bank),  64'(m_bank));
        check({nm, "_drops"}, 64'(bus.dropped_frames), 64'(exp_drops()));
    endtask

    task automatic begin_frame();
        bus.cap_done = 1'b0;
        bus.cap_we   = 1'b1;
        bus.cap_addr = ADDR_W'($urandom_range(FW - 1));
        bus.cap_data = $urandom;
        tick();
        m_cap      = 1'b1;
        bus.cap_we = 1'b0;
    endtask

    task automatic end_frame(input bit rel);
        logic good;
        bus.cap_we   = 1'b0;
        bus.cap_done = 1'b1;
        tick();
        m_cap = 1'b0;
        check("ready_pre_commit", 64'(bus.frame_ready), 64'(m_ready));
        bus.frame_release = rel;
        bus.cap_we   = 1'b1;
        bus.cap_addr = ADDR_W'($urandom_range(FW - 1));
        tick();
        bus.frame_release = 1'b0;
        if (rel) m_ready = 1'b0;
        good = (m_cnt == FW) && !m_bad && !m_ready;
        if (good) begin
            m_ready = 1'b1;
            m_bank  = m_wb;
            m_wb    = ~m_wb;
        end else m_drops++;
        m_cnt = 0;
        m_bad = 1'b0;
        tick();
        bus.cap_we = 1'b0;
        check_handoff("commit");
    endtask

    task automatic run_frame(input int nwords, input bit bad_addr, input bit contend, input bit rel);
        begin_frame();
        for (int i = 0; i < nwords; i++) begin
            if (contend || $urandom_range(3) == 0) begin
                bus.cap_we = 1'b0;
                tick();
            end
            bus.cap_we   = 1'b1;
            bus.cap_addr = ADDR_W'(i);
            bus.cap_data = $urandom;
            tick();
            if (bad_addr && i == nwords / 2) begin
                bus.cap_addr = FW_A;
                bus.cap_data = $urandom;
                tick();
            end
        end
        bus.cap_we = 1'b0;
        end_frame(rel);
    endtask

    task automatic release_frame();
        bus.frame_release = 1'b1;
        tick();
        bus.frame_release = 1'b0;
        m_ready = 1'b0;
        check_handoff("release");
    endtask

    task automatic read_phase(input int n);
        bus.det_req = 1'b1;
        repeat (n) tick();
        bus.det_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_frame_ready"}, 64'(bus.frame_ready), 64'd0);
        check({nm, "_frame_bank"},  64'(bus.frame_bank), 64'd0);
        check({nm, "_drops"},       64'(bus.dropped_frames), 64'd0);
        check({nm, "_mem_en"},      64'(bus.mem_en), 64'd0);
        check({nm, "_mem_we"},      64'(bus.mem_we), 64'd0);
        check({nm, "_mem_addr"},    64'(bus.mem_addr), 64'd0);
        check({nm, "_mem_wdata"},   64'(bus.mem_wdata), 64'd0);
        check({nm, "_rd_valid"},    64'(bus.det_rd_valid), 64'd0);
        check({nm, "_rd_data"},     64'(bus.det_rd_data), 64'd0);
        check({nm, "_det_gnt"},     64'(bus.det_gnt), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.cap_we        = 1'b0;
        bus.cap_addr      = '0;
        bus.cap_data      = '0;
        bus.cap_done      = 1'b1;
        bus.det_req       = 1'b0;
        bus.det_addr      = '0;
        bus.frame_release = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Short frame is dropped.
        run_frame(FW - 1, 1'b0, 1'b0, 1'b0);
        check("short_ready", 64'(bus.frame_ready), 64'd0);

        // Full frame rewrites bank 0 and is committed there.
        run_frame(FW, 1'b0, 1'b0, 1'b0);
        check("full_ready", 64'(bus.frame_ready), 64'd1);
        check("full_bank",  64'(bus.frame_bank),  64'd0);
        read_phase(30);

        // Second frame completes while bank 0 is held; reads contend with alternate-cycle writes.
        bus.det_req = 1'b1;
        run_frame(FW, 1'b0, 1'b1, 1'b0);
        bus.det_req = 1'b0;
        check("held_bank", 64'(bus.frame_bank), 64'd0);
        repeat (3) tick();

        // Release, then a stray release while nothing is held.
        release_frame();
        release_frame();

        // Third frame lands in bank 1.
        run_frame(FW, 1'b0, 1'b0, 1'b0);
        check("third_ready", 64'(bus.frame_ready), 64'd1);
        check("third_bank",  64'(bus.frame_bank),  64'd1);
        read_phase(20);

        // Release in the commit cycle lets the new frame in.
        run_frame(FW, 1'b0, 1'b0, 1'b1);
        check("relcommit_ready", 64'(bus.frame_ready), 64'd1);
        check("relcommit_bank",  64'(bus.frame_bank),  64'd0);
        read_phase(20);

        // Out-of-range address poisons an otherwise full frame.
        release_frame();
        run_frame(FW, 1'b1, 1'b0, 1'b0);
        check("badaddr_ready", 64'(bus.frame_ready), 64'd0);
        run_frame(FW, 1'b0, 1'b0, 1'b0);
        read_phase(10);

        // Reset in the middle of a capture while a frame is held.
        begin_frame();
        for (int i = 0; i < 10; i++) begin
            bus.cap_we   = 1'b1;
            bus.cap_addr = ADDR_W'(i);
            bus.cap_data = $urandom;
            tick();
        end
        bus.cap_we   = 1'b0;
        bus.cap_done = 1'b1;
        rst = 1'b1;
        tick();
        m_cap = 1'b0; m_wb = 1'b0; m_ready = 1'b0; m_bank = 1'b0;
        m_bad = 1'b0; m_cnt = 0; m_drops = 0;
        check_zero("midreset");
        rst = 1'b0;
        tick();

        // Write bank restarts at 0 after reset.
        run_frame(FW, 1'b0, 1'b0, 1'b0);
        check("postreset_bank", 64'(bus.frame_bank), 64'd0);
        read_phase(10);

        // Empty frames push the drop counter through saturation.
        repeat (260) run_frame(0, 1'b0, 1'b0, 1'b0);

        repeat (4) tick();
        check("wq_empty", 64'(wq.size()), 64'd0);
        check("rq_empty", 64'(rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
